// File: rtl/pixel_packer.sv
// Converts a stream of 24-bit RGB pixels into 32-bit little-endian framebuffer words,
// using RGB565 (modes 0/1) or packed RGB888 (modes 2/3) storage.
module pixel_packer (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [31:0] selector,
    input  logic        round_nearest,
    input  logic [23:0] pix_in,
    input  logic        pix_valid,
    input  logic        pix_last,
    output logic        pix_ready,
    output logic [31:0] word_out,
    output logic [3:0]  word_be,
    output logic        word_last,
    output logic        word_valid,
    input  logic        word_ready
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both high.
    // valid never depends on ready, and a raised valid is held with stable data until accepted.
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

    state_t      state_q, state_d;
    logic [1:0]  ph_q, ph_d;
    logic [23:0] res_q, res_d;
    logic [1:0]  mode_q, mode_d;
    logic        discard_q, discard_d;

    logic        out_free, accept;
    logic [1:0]  cur_mode;
    logic        cur_565, cur_discard;
    logic        load, load_last;
    logic [31:0] load_word;
    logic [3:0]  load_be;

    logic [5:0]  r_sh, b_sh;
    logic [6:0]  g_sh;
    logic [4:0]  r5, b5;
    logic [5:0]  g6;
    logic [15:0] px565;

    assign out_free  = !word_valid || word_ready;
    assign pix_ready = out_free && (state_q != FLUSH);
    assign accept    = pix_valid && pix_ready;

    // Mode is taken live from selector only for the first pixel of a transfer.
    assign cur_mode    = (state_q == IDLE) ? selector[1:0] : mode_q;
    assign cur_discard = (state_q == IDLE) ? (selector[31:2] != 30'd0) : discard_q;
    assign cur_565     = (cur_mode == 2'd0) || (cur_mode == 2'd1);

    always_comb begin
        r_sh = 6'((9'(pix_in[23:16]) + 9'd4) >> 3);
        g_sh = 7'((9'(pix_in[15:8])  + 9'd2) >> 2);
        b_sh = 6'((9'(pix_in[7:0])   + 9'd4) >> 3);
        if (round_nearest) begin
            r5 = r_sh[5] ? 5'd31 : r_sh[4:0];
            g6 = g_sh[6] ? 6'd63 : g_sh[5:0];
            b5 = b_sh[5] ? 5'd31 : b_sh[4:0];
        end else begin
            r5 = pix_in[23:19];
            g6 = pix_in[15:10];
            b5 = pix_in[7:3];
        end
        px565 = {r5, g6, b5};
    end

    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q;
        res_d     = res_q;
        mode_d    = mode_q;
        discard_d = discard_q;
        load      = 1'b0;
        load_word = 32'd0;
        load_be   = 4'b0000;
        load_last = 1'b0;
        case (state_q)
            FLUSH: begin
                if (out_free) begin
                    load      = 1'b1;
                    load_word = {8'h00, res_q};
                    // ph advanced past 1 leaves two residue bytes, past 2 leaves one.
                    load_be   = (ph_q == 2'd2) ? 4'b0011 : 4'b0001;
                    load_last = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                if (accept) begin
                    mode_d    = cur_mode;
                    discard_d = cur_discard;
                    state_d   = pix_last ? IDLE : RUN;
                    if (cur_discard) begin
                        load = 1'b0;
                    end else if (cur_565) begin
                        if (!ph_q[0]) begin
                            if (pix_last) begin
                                load      = 1'b1;
                                load_word = {16'h0000, px565};
                                load_be   = 4'b0011;
                                load_last = 1'b1;
                            end else begin
                                res_d = {8'h00, px565};
                                ph_d  = 2'd1;
                            end
                        end else begin
                            load      = 1'b1;
                            load_word = {px565, res_q[15:0]};
                            load_be   = 4'b1111;
                            load_last = pix_last;
                            ph_d      = 2'd0;
                            res_d     = 24'd0;
                        end
                    end else begin
                        case (ph_q)
                            2'd0: begin
                                if (pix_last) begin
                                    load      = 1'b1;
                                    load_word = {8'h00, pix_in};
                                    load_be   = 4'b0111;
                                    load_last = 1'b1;
                                end else begin
                                    res_d = pix_in;
                                    ph_d  = 2'd1;
                                end
                            end
                            2'd1: begin
                                load      = 1'b1;
                                load_word = {pix_in[7:0], res_q};
                                load_be   = 4'b1111;
                                res_d     = {8'h00, pix_in[23:8]};
                                ph_d      = 2'd2;
                                if (pix_last) state_d = FLUSH;
                            end
                            2'd2: begin
                                load      = 1'b1;
                                load_word = {pix_in[15:0], res_q[15:0]};
                                load_be   = 4'b1111;
                                res_d     = {16'h0000, pix_in[23:16]};
                                ph_d      = 2'd3;
                                if (pix_last) state_d = FLUSH;
                            end
                            default: begin
                                load      = 1'b1;
                                load_word = {pix_in, res_q[7:0]};
                                load_be   = 4'b1111;
                                load_last = pix_last;
                                res_d     = 24'd0;
                                ph_d      = 2'd0;
                            end
                        endcase
                    end
                end
            end
        endcase
        if (state_d == IDLE) begin
            ph_d  = 2'd0;
            res_d = 24'd0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            ph_q      <= 2'd0;
            res_q     <= 24'd0;
            mode_q    <= 2'd0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            res_q     <= res_d;
            mode_q    <= mode_d;
            discard_q <= discard_d;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            word_valid <= 1'b0;
            word_out   <= 32'd0;
            word_be    <= 4'b0000;
            word_last  <= 1'b0;
        end else if (load) begin
            word_valid <= 1'b1;
            word_out   <= load_word;
            word_be    <= load_be;
            word_last  <= load_last;
        end else if (word_ready) begin
            word_valid <= 1'b0;
        end
    end

endmodule
